transaction_responder: RTL and testbench

TRANSACTION_RESPONDER -- requirements
Module: transaction_responder

---
 rtl/transaction_responder.sv | 173 +++++++++++++++++
 tb/tb_transaction_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/transaction_responder.sv
// Responder for the transaction controller: animates travel codes, then runs the
// requested verification step (amount check, signature check, nonce mining, finish).
module transaction_responder #(
  parameter int          TRAVEL_CYCLES = 4,
  parameter int          DIFF_BITS     = 4,
  parameter logic [7:0]  SIG_KEY       = 8'hA5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [2:0] step,
  input  logic [2:0] travel,
  input  logic [7:0] balance,
  input  logic [7:0] amount,
  input  logic [7:0] signature,
  input  logic [7:0] sender_id,
  output logic       done_travel,
  output logic       done_step,
  output logic [2:0] travel_pos,
  output logic       busy,
  output logic       amount_ok,
  output logic       sig_ok,
  output logic       mined,
  output logic [7:0] nonce,
  output logic [7:0] new_balance,
  output logic       tx_committed,
  output logic       tx_rejected
);

  typedef enum logic [2:0] {IDLE, TRAVEL, DONE_T, EXEC, MINE, DONE_S} state_t;

  localparam logic [2:0] OP_AMOUNT = 3'b001;
  localparam logic [2:0] OP_SIG    = 3'b010;
  localparam logic [2:0] OP_MINE   = 3'b011;
  localparam logic [2:0] OP_FINISH = 3'b100;
  localparam logic [3:0] CNT_LAST  = 4'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DIFF_MASK = 8'((1 << DIFF_BITS) - 1);

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d, trav_q, trav_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] nonce_q, nonce_d, nb_q, nb_d;
  logic       aok_q, aok_d, sok_q, sok_d, mined_q, mined_d;
  logic       com_q, com_d, rej_q, rej_d;
  logic [7:0] hash;
  logic       hit;

  // Nibble-swapped nonce keyed by the signature, one candidate per cycle.
  assign hash = (amount ^ nonce_q) + (signature ^ {nonce_q[3:0], nonce_q[7:4]});
  assign hit  = (hash & DIFF_MASK) == 8'd0;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    trav_d  = trav_q;
    cnt_d   = cnt_q;
    nonce_d = nonce_q;
    nb_d    = nb_q;
    aok_d   = aok_q;
    sok_d   = sok_q;
    mined_d = mined_q;
    com_d   = com_q;
    rej_d   = rej_q;
    case (state_q)
      IDLE: begin
        if (travel != 3'b000) begin
          state_d = TRAVEL;
          op_d    = step;
          trav_d  = travel;
          cnt_d   = 4'd0;
        end else if (step == OP_FINISH) begin
          state_d = EXEC;
          op_d    = OP_FINISH;
        end else if (op_q == OP_MINE) begin
          state_d = MINE;
          nonce_d = 8'd0;
        end else if (op_q != 3'b000) begin
          state_d = EXEC;
        end
      end
      TRAVEL: begin
        cnt_d = cnt_q + 4'd1;
        // Dropping the travel code aborts the animation and forgets the step.
        if (travel == 3'b000) begin
          state_d = IDLE;
          op_d    = 3'b000;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE_T;
        end
      end
      DONE_T: state_d = IDLE;
      EXEC: begin
        case (op_q)
          OP_AMOUNT: begin
            aok_d   = (amount != 8'd0) && (amount <= balance);
            sok_d   = 1'b0;
            mined_d = 1'b0;
            com_d   = 1'b0;
            rej_d   = 1'b0;
            nonce_d = 8'd0;
          end
          OP_SIG: sok_d = (signature == (sender_id ^ SIG_KEY));
          OP_FINISH: begin
            if (aok_q && sok_q && mined_q) begin
              nb_d  = balance - amount;
              com_d = 1'b1;
            end else begin
              rej_d = 1'b1;
            end
          end
          default: ;
        endcase
        state_d = DONE_S;
      end
      MINE: begin
        if (hit) begin
          mined_d = 1'b1;
          state_d = DONE_S;
        end else if (nonce_q == 8'hFF) begin
          mined_d = 1'b0;
          state_d = DONE_S;
        end else begin
          nonce_d = nonce_q + 8'd1;
        end
      end
      DONE_S: begin
        state_d = IDLE;
        op_d    = 3'b000;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      trav_q  <= 3'b000;
      cnt_q   <= 4'd0;
      nonce_q <= 8'd0;
      nb_q    <= 8'd0;
      aok_q   <= 1'b0;
      sok_q   <= 1'b0;
      mined_q <= 1'b0;
      com_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      trav_q  <= trav_d;
      cnt_q   <= cnt_d;
      nonce_q <= nonce_d;
      nb_q    <= nb_d;
      aok_q   <= aok_d;
      sok_q   <= sok_d;
      mined_q <= mined_d;
      com_q   <= com_d;
      rej_q   <= rej_d;
    end
  end

  assign done_travel  = (state_q == DONE_T);
  assign done_step    = (state_q == DONE_S);
  assign travel_pos   = (state_q == TRAVEL || state_q == DONE_T) ? trav_q : 3'b000;
  assign busy         = (state_q != IDLE);
  assign amount_ok    = aok_q;
  assign sig_ok       = sok_q;
  assign mined        = mined_q;
  assign nonce        = nonce_q;
  assign new_balance  = nb_q;
  assign tx_committed = com_q;
  assign tx_rejected  = rej_q;

endmodule

// File: tb/tb_transaction_responder.sv
// Randomised scoreboard bench for transaction_responder with a step-level reference model.
module tb_transaction_responder;

  localparam int         TRAVEL_CYCLES = 4;
  localparam int         DIFF_BITS     = 4;
  localparam logic [7:0] SIG_KEY       = 8'hA5;
  localparam int         W             = 25;

  logic       clock, resetn;
  logic [2:0] step, travel;
  logic [7:0] balance, amount, signature, sender_id;
  logic       done_travel, done_step, busy;
  logic [2:0] travel_pos;
  logic       amount_ok, sig_ok, mined, tx_committed, tx_rejected;
  logic [7:0] nonce, new_balance;

  transaction_responder #(
    .TRAVEL_CYCLES(TRAVEL_CYCLES), .DIFF_BITS(DIFF_BITS), .SIG_KEY(SIG_KEY)
  ) dut (
    .clock(clock), .resetn(resetn), .step(step), .travel(travel),
    .balance(balance), .amount(amount), .signature(signature), .sender_id(sender_id),
    .done_travel(done_travel), .done_step(done_step), .travel_pos(travel_pos),
    .busy(busy), .amount_ok(amount_ok), .sig_ok(sig_ok), .mined(mined),
    .nonce(nonce), .new_balance(new_balance),
    .tx_committed(tx_committed), .tx_rejected(tx_rejected)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_dt     = 0;
  int n_ds     = 0;
  logic [W-1:0] exp_q[$];

  // reference model of the visible result registers
  logic       m_aok, m_sok, m_mined, m_com, m_rej;
  logic [7:0] m_nonce, m_nb;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endfunction

  function automatic void model_reset();
    m_aok = 0; m_sok = 0; m_mined = 0; m_com = 0; m_rej = 0; m_nonce = 0; m_nb = 0;
  endfunction

  function automatic int ref_hash(input int a, input int s, input int n);
    int sw;
    sw = ((n % 16) * 16) + (n / 16);
    return ((a ^ n) + (s ^ sw)) % 256;
  endfunction

  function automatic void model_step(input int op);
    case (op)
      1: begin
        m_aok = (amount != 0) && (amount <= balance);
        m_sok = 0; m_mined = 0; m_com = 0; m_rej = 0; m_nonce = 0;
      end
      2: m_sok = (signature == (sender_id ^ SIG_KEY));
      3: begin
        m_mined = 0;
        m_nonce = 8'd255;
        for (int n = 0; n < 256; n++) begin
          if (ref_hash(amount, signature, n) % (1 << DIFF_BITS) == 0) begin
            m_mined = 1;
            m_nonce = 8'(n);
            break;
          end
        end
      end
      4: begin
        if (m_aok && m_sok && m_mined) begin
          m_nb  = 8'((int'(balance) - int'(amount) + 256) % 256);
          m_com = 1;
        end else begin
          m_rej = 1;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_vec(input logic kind, input logic [2:0] pos);
    return {kind, pos, m_aok, m_sok, m_mined, m_nonce, m_nb, m_com, m_rej};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (resetn && (done_travel || done_step)) begin
      logic [W-1:0] act;
      logic [W-1:0] e;
      act = {done_step, travel_pos, amount_ok, sig_ok, mined, nonce, new_balance,
             tx_committed, tx_rejected};
      check("pulse_overlap", 32'(done_travel & done_step), 32'd0);
      if (done_travel) n_dt++;
      if (done_step) n_ds++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got %0h, expected no pulse", act);
      end else begin
        e = exp_q.pop_front();
        check("response", 32'(act), 32'(e));
      end
    end
  end

  // ---------------- driver tasks (all start and end at a negedge) ----------------
  task automatic run_travel(input logic [2:0] tc, input logic [2:0] sc);
    int cyc;
    travel = tc;
    step   = sc;
    exp_q.push_back(exp_vec(1'b0, tc));
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!done_travel && cyc < 40);
    check("travel_latency", 32'(cyc), 32'(TRAVEL_CYCLES + 1));
    travel = 3'b000;
    step   = 3'b000;
  endtask

  task automatic wait_step(input int lat);
    int cyc;
    cyc = 0;
    do begin @(negedge clock); cyc++; end while (!done_step && cyc < 400);
    check("step_latency", 32'(cyc), 32'(lat));
    @(negedge clock);
  endtask

  task automatic do_op(input logic [2:0] tc, input logic [2:0] sc);
    run_travel(tc, sc);
    if (sc != 3'b000) begin
      model_step(int'(sc));
      exp_q.push_back(exp_vec(1'b1, 3'b000));
      wait_step(sc == 3'b011 ? int'(m_nonce) + 3 : 3);
    end else begin
      repeat (3) @(negedge clock);
      check("idle_after_travel", 32'(busy), 32'd0);
    end
  endtask

  task automatic do_finish();
    step = 3'b100;
    model_step(4);
    exp_q.push_back(exp_vec(1'b1, 3'b000));
    @(posedge clock);
    #1 step = 3'b000;
    wait_step(2);
  endtask

  task automatic do_abort(input logic [2:0] tc, input int k);
    int dt0, ds0;
    dt0 = n_dt;
    ds0 = n_ds;
    travel = tc;
    step   = 3'b001;
    repeat (k) @(negedge clock);
    travel = 3'b000;
    step   = 3'b000;
    repeat (TRAVEL_CYCLES + 4) @(negedge clock);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_pos", 32'(travel_pos), 32'd0);
    check("abort_pulses", 32'((n_dt - dt0) + (n_ds - ds0)), 32'd0);
  endtask

  task automatic random_data();
    balance   = 8'($urandom_range(255, 0));
    sender_id = 8'($urandom_range(255, 0));
    case ($urandom_range(3, 0))
      0: amount = 8'd0;
      1: amount = (balance == 8'hFF) ? 8'hFF : 8'($urandom_range(255, int'(balance) + 1));
      default: amount = 8'($urandom_range(int'(balance), 0));
    endcase
    signature = ($urandom_range(1, 0) == 1) ? (sender_id ^ SIG_KEY) : 8'($urandom_range(255, 0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    resetn = 1'b0; step = 0; travel = 0;
    balance = 0; amount = 0; signature = 0; sender_id = 0;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'({done_travel, done_step, travel_pos, busy, amount_ok, sig_ok,
          mined, nonce, new_balance, tx_committed, tx_rejected}), 32'd0);
    resetn = 1'b1;
    @(negedge clock);

    // amount step after travel, balance 10 / amount 3
    balance = 8'd10; amount = 8'd3; sender_id = 8'h12; signature = 8'hB7;
    do_op(3'b001, 3'b001);
    check("amount_ok_valid", 32'(amount_ok), 32'd1);

    // amount boundaries
    amount = 8'd0;
    do_op(3'b010, 3'b001);
    check("amount_ok_zero", 32'(amount_ok), 32'd0);
    amount = 8'd11;
    do_op(3'b011, 3'b001);
    check("amount_ok_over", 32'(amount_ok), 32'd0);

    // mining: amount 5, signature 0 hits at nonce 5
    amount = 8'd5; signature = 8'h00;
    do_op(3'b001, 3'b011);
    check("mine_nonce", 32'(nonce), 32'd5);
    check("mine_flag", 32'(mined), 32'd1);

    // full committed transaction
    amount = 8'd3; signature = 8'hB7;
    do_op(3'b001, 3'b001);
    do_op(3'b010, 3'b010);
    do_op(3'b011, 3'b011);
    do_finish();
    check("commit_sig_ok", 32'(sig_ok), 32'd1);
    check("commit_flag", 32'(tx_committed), 32'd1);
    check("commit_balance", 32'(new_balance), 32'd7);

    // same flow with a bad signature
    signature = 8'h00;
    do_op(3'b001, 3'b001);
    do_op(3'b010, 3'b010);
    do_op(3'b011, 3'b011);
    do_finish();
    check("reject_flag", 32'(tx_rejected), 32'd1);
    check("reject_balance", 32'(new_balance), 32'd7);

    // travel with no step, and aborted travel
    do_op(3'b101, 3'b000);
    do_abort(3'b010, 2);
    do_abort(3'b110, TRAVEL_CYCLES);

    // reset while mining at nonce 3
    amount = 8'd5; signature = 8'h00;
    run_travel(3'b001, 3'b011);
    repeat (5) @(negedge clock);
    check("premine_nonce", 32'(nonce), 32'd3);
    check("premine_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    @(negedge clock);
    check("midmine_reset", 32'({done_travel, done_step, travel_pos, busy, amount_ok, sig_ok,
          mined, nonce, new_balance, tx_committed, tx_rejected}), 32'd0);
    resetn = 1'b1;
    model_reset();
    @(negedge clock);

    // randomised traffic
    random_data();
    for (int i = 0; i < 60; i++) begin
      int r;
      if ($urandom_range(4, 0) == 0) random_data();
      r = $urandom_range(5, 0);
      case (r)
        0:       do_op(3'($urandom_range(7, 1)), 3'b000);
        4:       do_finish();
        5:       do_abort(3'($urandom_range(7, 1)), $urandom_range(TRAVEL_CYCLES, 1));
        default: do_op(3'($urandom_range(7, 1)), 3'(r));
      endcase
    end

    repeat (5) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
